// File: rtl/stopwatch_input_conditioner_if.sv
// Key and tick signal bundle between the stopwatch control logic and the
// input conditioner. The conditioner is the slave: it consumes the raw keys
// and prescaler controls and returns the conditioned key events and tick.
interface stopwatch_input_conditioner_if;
    // Raw active-low keys: bit 0 = reset key, bit 1 = start/pause, bit 2 = display/stop
    logic [2:0] key_n;
    // Prescaler controls
    logic       run_en;
    logic       tick_clr;
    // Conditioned key state and one-cycle edge pulses (1 = pressed)
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;
    // One-cycle pulse every TICK_CYCLES enabled cycles
    logic       tick_10ms;

    modport master (
        output key_n,
        output run_en,
        output tick_clr,
        input  key_level,
        input  key_press,
        input  key_release,
        input  tick_10ms
    );

    modport slave (
        input  key_n,
        input  run_en,
        input  tick_clr,
        output key_level,
        output key_press,
        output key_release,
        output tick_10ms
    );
endinterface

// File: rtl/stopwatch_input_conditioner.sv
// Stopwatch input conditioner: synchronises and debounces three active-low
// push buttons into a clean level plus press/release pulses per key, and
// runs an independent 10 ms tick prescaler.
//
// Key path timing: a raw edge crosses the 2-flop synchronizer in 2 edges,
// then must stay different from the accepted level for DEBOUNCE_CYCLES
// consecutive cycles, so the level and its pulse appear exactly
// DEBOUNCE_CYCLES+2 edges after the raw edge. Any bounce back to the
// accepted level clears the counter, so only an uninterrupted run counts.
module stopwatch_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    stopwatch_input_conditioner_if.slave  io
);

    localparam int unsigned NUM_KEYS = 3;

    // Counter widths just large enough to hold the terminal counts
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync1_d;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] sync2_d;
    logic [NUM_KEYS-1:0] key_s;

    // Two-stage shift of the raw keys into the clk domain
    always_comb begin
        sync1_d = io.key_n;
        sync2_d = sync1_q;
    end

    // Synchronizer flops reset to the released (raw high) value so that a
    // key held through reset still needs a full debounce afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= {NUM_KEYS{1'b1}};
            sync2_q <= {NUM_KEYS{1'b1}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Active-high view of the synchronised keys
    assign key_s = ~sync2_q;

    // ------------------------------------------------------------------
    // Per-key debouncers
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_level_vec;
    logic [NUM_KEYS-1:0] key_press_vec;
    logic [NUM_KEYS-1:0] key_release_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;
            logic            level_q;
            logic            level_d;
            logic            press_q;
            logic            press_d;
            logic            release_q;
            logic            release_d;

            // Count consecutive mismatch cycles; accept the new level on
            // the cycle after the count reaches its terminal value
            always_comb begin
                cnt_d     = '0;
                level_d   = level_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                if (key_s[gi] != level_q) begin
                    if (cnt_q == DB_MAX) begin
                        level_d   = ~level_q;
                        press_d   = ~level_q;
                        release_d = level_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Debounce state; pulses are registered so they coincide with
            // the level change and press/release are mutually exclusive
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    cnt_q     <= cnt_d;
                    level_q   <= level_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                end
            end

            assign key_level_vec[gi]   = level_q;
            assign key_press_vec[gi]   = press_q;
            assign key_release_vec[gi] = release_q;
        end
    endgenerate

    assign io.key_level   = key_level_vec;
    assign io.key_press   = key_press_vec;
    assign io.key_release = key_release_vec;

    // ------------------------------------------------------------------
    // Tick prescaler (independent of the key logic)
    // ------------------------------------------------------------------
    logic [TK_W-1:0] tick_cnt_q;
    logic [TK_W-1:0] tick_cnt_d;
    logic            tick_q;
    logic            tick_d;

    // Clear beats run; count 0..TICK_CYCLES-1 and pulse on the wrap
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        if (io.tick_clr) begin
            tick_cnt_d = '0;
        end else if (io.run_en) begin
            if (tick_cnt_q == TK_MAX) begin
                tick_cnt_d = '0;
                tick_d     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // Prescaler state
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign io.tick_10ms = tick_q;

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
// Scoreboard bench for stopwatch_input_conditioner (DEBOUNCE_CYCLES=8,
// TICK_CYCLES=5). Stimulus pushes expected output events stamped with the
// clock edge they must appear after; a monitor on the falling edge pops and
// compares whenever an event is due or the DUT shows a pulse.
module tb_stopwatch_input_conditioner;

    localparam int DB = 8;
    localparam int TK = 5;
    localparam int LAT = DB + 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Edge counter: value seen at a falling edge = number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    stopwatch_input_conditioner_if sw_if ();

    stopwatch_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES    (TK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (sw_if.slave)
    );

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
        logic       tick;
        logic [2:0] level;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input int c, input logic [2:0] p, input logic [2:0] r,
                            input logic t, input logic [2:0] l);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.tick = t; e.level = l;
        exp_q.push_back(e);
    endtask

    // Monitor: compares due events and flags unexpected pulses
    always @(negedge clk) begin
        exp_t e;
        logic active;
        active = (|sw_if.key_press) | (|sw_if.key_release) | sw_if.tick_10ms;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL missed_event exp_cyc=%0d now=%0d", e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            total++;
            if ({sw_if.key_press, sw_if.key_release, sw_if.tick_10ms, sw_if.key_level}
                !== {e.press, e.rel, e.tick, e.level}) begin
                bad++;
                $display("FAIL event@%0d got press=%b rel=%b tick=%b level=%b exp press=%b rel=%b tick=%b level=%b",
                         cyc, sw_if.key_press, sw_if.key_release, sw_if.tick_10ms, sw_if.key_level,
                         e.press, e.rel, e.tick, e.level);
            end else begin
                $display("event@%0d press=%b rel=%b tick=%b level=%b ok",
                         cyc, sw_if.key_press, sw_if.key_release, sw_if.tick_10ms, sw_if.key_level);
            end
        end else if (active) begin
            total++; bad++;
            $display("FAIL unexpected_event@%0d got press=%b rel=%b tick=%b exp no pulse",
                     cyc, sw_if.key_press, sw_if.key_release, sw_if.tick_10ms);
        end
        if (active) begin
            total++;
            if ((sw_if.key_press & sw_if.key_release) != 3'b000) begin
                bad++;
                $display("FAIL press_and_release@%0d got %b exp 000",
                         cyc, sw_if.key_press & sw_if.key_release);
            end
        end
    end

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, expv);
        end else begin
            $display("check %s = %b ok", name, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for all expected events, then a quiet window for strays
    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
        cycles(12);
    endtask

    function automatic logic [9:0] outs();
        return {sw_if.key_level, sw_if.key_press, sw_if.key_release, sw_if.tick_10ms};
    endfunction

    int t;

    initial begin
        reset          = 1'b1;
        sw_if.key_n    = 3'b000;
        sw_if.run_en   = 1'b0;
        sw_if.tick_clr = 1'b0;

        // Reset with all keys pressed: outputs 0 during reset, all keys
        // accepted together 10 edges after release of reset
        cycles(1); chk("reset_outs_1", outs(), 10'd0);
        cycles(1); chk("reset_outs_2", outs(), 10'd0);
        cycles(1); chk("reset_outs_3", outs(), 10'd0);
        reset = 1'b0;
        t = cyc;
        push_exp(t + LAT, 3'b111, 3'b000, 1'b0, 3'b111);
        drain(40);
        sw_if.key_n = 3'b111;
        t = cyc;
        push_exp(t + LAT, 3'b000, 3'b111, 1'b0, 3'b000);
        drain(40);

        // Short glitch on key 1: no level change, no pulse
        sw_if.key_n = 3'b101;
        cycles(5);
        sw_if.key_n = 3'b111;
        cycles(20);
        chk("glitch_level", {7'd0, sw_if.key_level}, 10'd0);

        // Press for 20 cycles then release on key 1
        sw_if.key_n = 3'b101;
        t = cyc;
        push_exp(t + LAT, 3'b010, 3'b000, 1'b0, 3'b010);
        push_exp(t + 20 + LAT, 3'b000, 3'b010, 1'b0, 3'b000);
        cycles(15);
        chk("held_level", {7'd0, sw_if.key_level}, 10'd2);
        cycles(5);
        sw_if.key_n = 3'b111;
        drain(40);

        // Bounce on key 0: 7 low, 1 high, then held low -> count restarts
        sw_if.key_n = 3'b110;
        t = cyc;
        cycles(7);
        sw_if.key_n = 3'b111;
        cycles(1);
        sw_if.key_n = 3'b110;
        push_exp(t + 8 + LAT, 3'b001, 3'b000, 1'b0, 3'b001);
        drain(40);
        sw_if.key_n = 3'b111;
        t = cyc;
        push_exp(t + LAT, 3'b000, 3'b001, 1'b0, 3'b000);
        drain(40);

        // Tick with pause: ticks at 5 and 10, hold at 2, next tick after 3
        sw_if.run_en = 1'b1;
        t = cyc;
        push_exp(t + 5, 3'b000, 3'b000, 1'b1, 3'b000);
        push_exp(t + 10, 3'b000, 3'b000, 1'b1, 3'b000);
        push_exp(t + 19, 3'b000, 3'b000, 1'b1, 3'b000);
        cycles(12);
        sw_if.run_en = 1'b0;
        cycles(4);
        sw_if.run_en = 1'b1;
        cycles(3);
        sw_if.run_en = 1'b0;
        drain(20);

        // tick_clr at count 3: no tick that cycle, next tick 5 cycles later
        sw_if.run_en = 1'b1;
        t = cyc;
        push_exp(t + 9, 3'b000, 3'b000, 1'b1, 3'b000);
        cycles(3);
        sw_if.tick_clr = 1'b1;
        cycles(1);
        sw_if.tick_clr = 1'b0;
        cycles(5);
        sw_if.run_en = 1'b0;
        drain(20);

        // Reset mid-debounce on key 2 at count 5: partial count discarded
        sw_if.key_n = 3'b011;
        cycles(7);
        reset = 1'b1;
        cycles(1);
        chk("midreset_outs", outs(), 10'd0);
        cycles(1);
        reset = 1'b0;
        t = cyc;
        push_exp(t + LAT, 3'b100, 3'b000, 1'b0, 3'b100);
        drain(40);
        sw_if.key_n = 3'b111;
        t = cyc;
        push_exp(t + LAT, 3'b000, 3'b100, 1'b0, 3'b000);
        drain(40);
        chk("final_level", {7'd0, sw_if.key_level}, 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_conditioner.md
STOPWATCH_INPUT_CONDITIONER -- requirements
Module: stopwatch_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive stable cycles needed to accept a key change; legal range is 2 or more.
REQ-002 Parameter TICK_CYCLES, default 500000, SHALL set the clk cycles per tick_10ms pulse (10 ms at 50 MHz); legal range is 2 or more.
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_n  in  3  raw asynchronous keys, active-low; bit 0 = reset key, bit 1 = start/pause key, bit 2 = display/stop key.
REQ-006 run_en  in  1  enables the tick prescaler.
REQ-007 tick_clr  in  1  clears the tick prescaler.
REQ-008 key_level  out  3  debounced key state, 1 = pressed.
REQ-009 key_press  out  3  one-cycle pulse on each debounced press.
REQ-010 key_release  out  3  one-cycle pulse on each debounced release.
REQ-011 tick_10ms  out  1  one-cycle pulse once every TICK_CYCLES enabled cycles.

Function
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer, then be inverted to active-high; the synchronizer output is called s[i].
REQ-013 Each key SHALL have an independent debounce counter, sized to hold DEBOUNCE_CYCLES-1.
REQ-014 Counter rule: while s[i] == key_level[i], the counter SHALL be 0 on the next edge.
REQ-015 Counter rule: while s[i] != key_level[i] and the count < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-016 When s[i] != key_level[i] and the count == DEBOUNCE_CYCLES-1, then on the next edge: key_level[i] SHALL toggle and the counter SHALL clear to 0.
REQ-017 key_press[i] SHALL be 1 for exactly the one cycle in which key_level[i] goes 0 to 1; key_release[i] SHALL do the same for 1 to 0. Both are registered and coincide with the level change.
REQ-018 Latency from a raw key_n edge to the key_level/pulse change SHALL be exactly DEBOUNCE_CYCLES+2 clk edges.
REQ-019 Any mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL produce no level change and no pulse; each bounce restarts the count from 0.
REQ-020 Keys SHALL be fully independent; pulses on several keys in the same cycle are legal and SHALL all be output.
REQ-021 key_press[i] and key_release[i] SHALL never both be 1 in the same cycle.
REQ-022 The tick prescaler SHALL count 0..TICK_CYCLES-1.
REQ-023 Prescaler priority, highest first: reset, then tick_clr, then run_en.
REQ-024 tick_clr=1: count SHALL be set to 0 and tick_10ms SHALL be 0 on the next edge.
REQ-025 run_en=1 with count == TICK_CYCLES-1: count SHALL wrap to 0 and tick_10ms SHALL be 1 for one cycle on the next edge.
REQ-026 run_en=1 otherwise: count SHALL increment and tick_10ms SHALL be 0.
REQ-027 run_en=0 (and tick_clr=0): count SHALL hold and tick_10ms SHALL be 0.
REQ-028 The prescaler SHALL be independent of the key logic.

Reset
REQ-029 With reset=1 at an edge, the following SHALL all become 0: key_level, key_press, key_release, tick_10ms, all debounce counters and the prescaler.
REQ-030 The synchronizer flops SHALL reset to the released value (raw 1).
REQ-031 Reset asserted mid-debounce SHALL discard the partial count: no pulse is produced, and a new full DEBOUNCE_CYCLES+2 edges is needed after release.

Verification (DEBOUNCE_CYCLES=8, TICK_CYCLES=5)
REQ-032 Reset with all keys pressed: reset=1 for 3 cycles, key_n=3'b000 -> all outputs 0 during reset; key_level=3'b111 and key_press=3'b111 (one cycle) at the 10th edge after reset deasserts.
REQ-033 Short glitch: key_n[1] low 5 cycles then high -> key_level[1], key_press[1] and key_release[1] stay 0 throughout.
REQ-034 Press and release: key_n[1] low 20 cycles then high -> key_press[1] pulses once at edge 10 after the fall, key_level[1]=1; key_release[1] pulses once at edge 10 after the rise.
REQ-035 Tick with pause: run_en=1 for 12 cycles -> tick_10ms at cycles 5 and 10 only; then run_en=0 for 4 cycles -> no tick, count held at 2; run_en=1 again -> next tick after 3 cycles.
REQ-036 tick_clr: asserted with run_en=1 when count=3 -> no tick that cycle; next tick 5 enabled cycles later.
REQ-037 Reset mid-debounce: reset during key_n[2] press at debounce count 5 -> no key_press[2]; with the key held, key_press[2] asserts 10 edges after reset deasserts.
